// File: rtl/swarm_pkg.sv
// Shared types for the undo-log path: entry layout, id/slot types and the
// slot-relative address helper.
package swarm;

  typedef logic [3:0]  undo_id_t;
  typedef logic [3:0]  cq_slice_slot_t;
  typedef logic [31:0] undo_log_addr_t;
  typedef logic [31:0] undo_log_data_t;

  // One buffered undo-log record, in the order it is packed into the FIFO.
  typedef struct packed {
    cq_slice_slot_t slot;
    undo_id_t       id;
    undo_log_data_t data;
    undo_log_addr_t addr;
  } undo_log_entry_t;

  localparam int UNDO_LOG_ENTRIES_PER_SLOT = 8;

  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Byte address of an entry: base + ((slot*entries + id) * 8), full 64-bit math.
  function automatic logic [63:0] undo_log_slot_addr(input logic [63:0] base,
                                                     input cq_slice_slot_t slot,
                                                     input undo_id_t id,
                                                     input int entries_per_slot);
    logic [63:0] index;
    index = 64'(slot) * 64'(entries_per_slot) + 64'(id);
    return base + (index << 3);
  endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO. Head entry is visible combinationally on rd_data
// so a pop can move it straight into a downstream register.
module fifo #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LOG_DEPTH:0]   count_reg, count_next;
  logic                 full_reg;
  logic                 do_push, do_pop;

  assign do_push = push && !full_reg;
  assign do_pop  = pop && (count_reg != '0);
  assign rd_data = mem[rd_ptr_reg];
  assign empty   = (count_reg == '0);
  assign full    = full_reg;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop)
      count_next = count_reg + (LOG_DEPTH+1)'(1);
    else if (!do_push && do_pop)
      count_next = count_reg - (LOG_DEPTH+1)'(1);
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers, count and registered full flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + LOG_DEPTH'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + LOG_DEPTH'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == (LOG_DEPTH+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/undo_log_writer.sv
// Buffers undo-log entries and writes each one as a single 8-byte AXI beat
// into the per-slot undo-log region; reports durability through idle.
module undo_log_writer
  import swarm::*;
#(
  parameter int FIFO_LOG_DEPTH   = 3,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int ENTRIES_PER_SLOT = UNDO_LOG_ENTRIES_PER_SLOT
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           undo_log_valid,
  output logic           undo_log_ready,
  input  undo_id_t       undo_log_id,
  input  undo_log_addr_t undo_log_addr,
  input  undo_log_data_t undo_log_data,
  input  cq_slice_slot_t undo_log_slot,
  input  logic [63:0]    undo_log_base,
  output logic           l2_awvalid,
  input  logic           l2_awready,
  output logic [63:0]    l2_awaddr,
  output logic [3:0]     l2_awid,
  output logic [7:0]     l2_awlen,
  output logic [2:0]     l2_awsize,
  output logic [1:0]     l2_awburst,
  output logic           l2_wvalid,
  input  logic           l2_wready,
  output logic [511:0]   l2_wdata,
  output logic [63:0]    l2_wstrb,
  output logic           l2_wlast,
  output logic [3:0]     l2_wid,
  input  logic           l2_bvalid,
  output logic           l2_bready,
  input  logic [1:0]     l2_bresp,
  output logic           l2_arvalid,
  output logic           l2_rready,
  output logic           idle,
  output logic           overflow_err,
  output logic           bresp_err,
  output logic [31:0]    num_written
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  undo_log_entry_t wr_entry, head;
  logic            fifo_empty, fifo_full;
  logic            acc, in_range, push, pop;
  logic            ready_en_reg;
  logic            aw_pend_reg, w_pend_reg, aw_pend_next, w_pend_next;
  logic [63:0]     awaddr_reg, payload_reg;
  logic [OUT_W-1:0] outstanding_reg, outstanding_next;
  logic [OUT_W:0]  out_after_aw;
  logic            aw_hs, w_hs, b_hs, reg_free, idle_next;
  logic            idle_reg, overflow_reg, bresp_err_reg;
  logic [31:0]     num_written_reg;

  // Ready is held low through reset and otherwise follows the registered full flag.
  assign undo_log_ready = ready_en_reg && !fifo_full;
  assign acc      = undo_log_valid && undo_log_ready;
  assign in_range = 32'(undo_log_id) < 32'(ENTRIES_PER_SLOT);
  assign push     = acc && in_range;
  assign wr_entry = '{slot: undo_log_slot, id: undo_log_id,
                      data: undo_log_data, addr: undo_log_addr};

  fifo #(
    .WIDTH    ($bits(undo_log_entry_t)),
    .LOG_DEPTH(FIFO_LOG_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .push   (push),
    .wr_data(wr_entry),
    .pop    (pop),
    .rd_data(head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign aw_hs    = aw_pend_reg && l2_awready;
  assign w_hs     = w_pend_reg && l2_wready;
  assign b_hs     = l2_bvalid;
  assign reg_free = (!aw_pend_reg || aw_hs) && (!w_pend_reg || w_hs);
  // A pending AW that fires this cycle counts against the limit before the next pop.
  assign out_after_aw = {1'b0, outstanding_reg} + {{OUT_W{1'b0}}, aw_hs};
  assign pop = reg_free && !fifo_empty &&
               (out_after_aw < (OUT_W+1)'(MAX_OUTSTANDING));

  // Next-state for the output register valids, outstanding count and idle.
  always_comb begin
    aw_pend_next     = pop ? 1'b1 : (aw_pend_reg && !aw_hs);
    w_pend_next      = pop ? 1'b1 : (w_pend_reg && !w_hs);
    outstanding_next = outstanding_reg;
    if (aw_hs && !b_hs)
      outstanding_next = outstanding_reg + OUT_W'(1);
    else if (!aw_hs && b_hs && (outstanding_reg != '0))
      outstanding_next = outstanding_reg - OUT_W'(1);
    idle_next = fifo_empty && !push && !aw_pend_next && !w_pend_next &&
                (outstanding_next == '0);
  end

  // Output register, counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ready_en_reg    <= 1'b0;
      aw_pend_reg     <= 1'b0;
      w_pend_reg      <= 1'b0;
      awaddr_reg      <= '0;
      payload_reg     <= '0;
      outstanding_reg <= '0;
      idle_reg        <= 1'b1;
      overflow_reg    <= 1'b0;
      bresp_err_reg   <= 1'b0;
      num_written_reg <= '0;
    end else begin
      ready_en_reg    <= 1'b1;
      aw_pend_reg     <= aw_pend_next;
      w_pend_reg      <= w_pend_next;
      outstanding_reg <= outstanding_next;
      idle_reg        <= idle_next;
      if (pop) begin
        awaddr_reg  <= undo_log_slot_addr(undo_log_base, head.slot, head.id,
                                          ENTRIES_PER_SLOT);
        payload_reg <= {head.data, head.addr};
      end
      if (acc && !in_range)
        overflow_reg <= 1'b1;
      if (b_hs) begin
        num_written_reg <= num_written_reg + 32'd1;
        if (l2_bresp != 2'b00)
          bresp_err_reg <= 1'b1;
      end
    end
  end

  // The 8-byte payload is replicated into every lane; wstrb picks the real one.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign l2_wdata[gi*64 +: 64] = payload_reg;
    end
  endgenerate

  assign l2_awvalid = aw_pend_reg;
  assign l2_awaddr  = awaddr_reg;
  assign l2_awid    = 4'd0;
  assign l2_awlen   = 8'd0;
  assign l2_awsize  = AXI_SIZE_8B;
  assign l2_awburst = AXI_BURST_INCR;
  assign l2_wvalid  = w_pend_reg;
  assign l2_wstrb   = 64'hFF << {awaddr_reg[5:3], 3'b000};
  assign l2_wlast   = 1'b1;
  assign l2_wid     = 4'd0;
  assign l2_bready  = 1'b1;
  assign l2_arvalid = 1'b0;
  assign l2_rready  = 1'b1;

  assign idle         = idle_reg;
  assign overflow_err = overflow_reg;
  assign bresp_err    = bresp_err_reg;
  assign num_written  = num_written_reg;

endmodule

// File: tb/tb_undo_log_writer.sv
// Directed bench for undo_log_writer with a simple scripted AXI write slave.
module tb_undo_log_writer;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         undo_log_valid = 1'b0;
  logic         undo_log_ready;
  logic [3:0]   undo_log_id = '0;
  logic [31:0]  undo_log_addr = '0;
  logic [31:0]  undo_log_data = '0;
  logic [3:0]   undo_log_slot = '0;
  logic [63:0]  undo_log_base = 64'h1000;
  logic         l2_awvalid, l2_wvalid, l2_wlast, l2_bready, l2_arvalid, l2_rready;
  logic         l2_awready = 1'b1;
  logic         l2_wready = 1'b1;
  logic         l2_bvalid = 1'b0;
  logic [1:0]   l2_bresp = 2'b00;
  logic [63:0]  l2_awaddr, l2_wstrb;
  logic [3:0]   l2_awid, l2_wid;
  logic [7:0]   l2_awlen;
  logic [2:0]   l2_awsize;
  logic [1:0]   l2_awburst;
  logic [511:0] l2_wdata;
  logic         idle, overflow_err, bresp_err;
  logic [31:0]  num_written;

  int checks = 0;
  int errors = 0;
  int aw_cnt = 0;
  int w_cnt = 0;
  int b_sent = 0;
  logic [63:0]  aw_addr_q[$];
  logic [511:0] w_data_q[$];
  logic [63:0]  w_strb_q[$];

  undo_log_writer #(
    .FIFO_LOG_DEPTH  (3),
    .MAX_OUTSTANDING (4),
    .ENTRIES_PER_SLOT(8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .undo_log_valid(undo_log_valid), .undo_log_ready(undo_log_ready),
    .undo_log_id(undo_log_id), .undo_log_addr(undo_log_addr),
    .undo_log_data(undo_log_data), .undo_log_slot(undo_log_slot),
    .undo_log_base(undo_log_base),
    .l2_awvalid(l2_awvalid), .l2_awready(l2_awready), .l2_awaddr(l2_awaddr),
    .l2_awid(l2_awid), .l2_awlen(l2_awlen), .l2_awsize(l2_awsize),
    .l2_awburst(l2_awburst),
    .l2_wvalid(l2_wvalid), .l2_wready(l2_wready), .l2_wdata(l2_wdata),
    .l2_wstrb(l2_wstrb), .l2_wlast(l2_wlast), .l2_wid(l2_wid),
    .l2_bvalid(l2_bvalid), .l2_bready(l2_bready), .l2_bresp(l2_bresp),
    .l2_arvalid(l2_arvalid), .l2_rready(l2_rready),
    .idle(idle), .overflow_err(overflow_err), .bresp_err(bresp_err),
    .num_written(num_written)
  );

  always #5 clk = ~clk;

  // Slave-side recorder of every AW and W handshake; forgets history on reset.
  always @(posedge clk) begin
    if (!rstn) begin
      aw_cnt <= 0;
      w_cnt  <= 0;
      aw_addr_q.delete();
      w_data_q.delete();
      w_strb_q.delete();
    end else begin
      if (l2_awvalid && l2_awready) begin
        aw_cnt <= aw_cnt + 1;
        aw_addr_q.push_back(l2_awaddr);
      end
      if (l2_wvalid && l2_wready) begin
        w_cnt <= w_cnt + 1;
        w_data_q.push_back(l2_wdata);
        w_strb_q.push_back(l2_wstrb);
      end
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one entry from a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [3:0] s, input logic [3:0] i,
                      input logic [31:0] a, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    undo_log_valid = 1'b1;
    undo_log_slot  = s;
    undo_log_id    = i;
    undo_log_addr  = a;
    undo_log_data  = d;
    for (int n = 0; n < 50 && !ok; n++) begin
      ok = undo_log_ready;
      @(negedge clk);
    end
    undo_log_valid = 1'b0;
    check("push_accept", ok, 1'b1);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Return one OKAY B per outstanding AW for n cycles.
  task automatic run_auto(input int n);
    for (int c = 0; c < n; c++) begin
      if (aw_cnt > b_sent) begin
        l2_bvalid = 1'b1;
        b_sent++;
      end else begin
        l2_bvalid = 1'b0;
      end
      @(negedge clk);
    end
    l2_bvalid = 1'b0;
  endtask

  task automatic give_b(input logic [1:0] resp);
    l2_bvalid = 1'b1;
    l2_bresp  = resp;
    b_sent++;
    @(negedge clk);
    l2_bvalid = 1'b0;
    l2_bresp  = 2'b00;
  endtask

  initial begin
    int aw0, w0, lane, slot_k, id_k;
    logic [63:0] exp_addr;

    // Reset values
    wait_cyc(3);
    check("rst_ready", undo_log_ready, 1'b0);
    check("rst_awvalid", l2_awvalid, 1'b0);
    check("rst_wvalid", l2_wvalid, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_overflow", overflow_err, 1'b0);
    check("rst_bresp_err", bresp_err, 1'b0);
    check("rst_num_written", num_written, 32'd0);
    rstn = 1'b1;
    wait_cyc(1);
    check("ready_after_rst", undo_log_ready, 1'b1);
    $display("reset: checks=%0d errors=%0d", checks, errors);

    // Single entry: slot 2 id 3 -> 0x1000 + 19*8 = 0x1098, lane 3
    push(4'd2, 4'd3, 32'hDEAD0000, 32'h12345678);
    check("lat_t1_awvalid", l2_awvalid, 1'b0);
    wait_cyc(1);
    check("lat_t2_awvalid", l2_awvalid, 1'b1);
    check("lat_t2_wvalid", l2_wvalid, 1'b1);
    check("single_awaddr", l2_awaddr, 64'h1098);
    check("single_wstrb", l2_wstrb, 64'hFF00_0000);
    check("single_lane3", l2_wdata[255:192], 64'h12345678_DEAD0000);
    check("single_wdata_all", l2_wdata, {8{64'h12345678_DEAD0000}});
    check("single_awlen", l2_awlen, 8'd0);
    check("single_awsize", l2_awsize, 3'd3);
    check("single_awburst", l2_awburst, 2'b01);
    check("single_wlast", l2_wlast, 1'b1);
    check("single_busy", idle, 1'b0);
    wait_cyc(1);
    check("single_aw_done", l2_awvalid, 1'b0);
    give_b(2'b00);
    check("single_num_written", num_written, 32'd1);
    check("single_idle", idle, 1'b1);
    $display("single entry: checks=%0d errors=%0d", checks, errors);

    // Back-pressure: 9 entries with awready low, then drain in order
    l2_awready = 1'b0;
    for (int k = 0; k < 9; k++)
      push((k < 8) ? 4'd1 : 4'd2, (k < 8) ? 4'(k) : 4'd0,
           32'hA000_0000 + 32'(k), 32'h5000_0000 + 32'(k));
    check("bp_ready_low", undo_log_ready, 1'b0);
    wait_cyc(2);
    check("bp_ready_still_low", undo_log_ready, 1'b0);
    check("bp_no_aw", aw_cnt, 1);
    l2_awready = 1'b1;
    run_auto(60);
    check("bp_aw_count", aw_cnt, 10);
    check("bp_w_count", w_cnt, 10);
    for (int k = 0; k < 9; k++) begin
      slot_k   = (k < 8) ? 1 : 2;
      id_k     = (k < 8) ? k : 0;
      exp_addr = 64'h1000 + 64'((slot_k * 8 + id_k) * 8);
      lane     = int'(exp_addr[5:3]);
      check("bp_awaddr", aw_addr_q[1+k], exp_addr);
      check("bp_lane", w_data_q[1+k][lane*64 +: 64],
            {32'h5000_0000 + 32'(k), 32'hA000_0000 + 32'(k)});
      check("bp_wstrb", w_strb_q[1+k], 64'hFF << (lane * 8));
    end
    check("bp_num_written", num_written, 32'd10);
    check("bp_idle", idle, 1'b1);
    $display("back-pressure: checks=%0d errors=%0d", checks, errors);

    // Outstanding limit: no B -> exactly 4 AWs; one B frees one more
    aw0 = aw_cnt;
    for (int k = 0; k < 6; k++)
      push(4'd3, 4'(k), 32'hB000_0000 + 32'(k), 32'h6000_0000 + 32'(k));
    wait_cyc(8);
    check("lim_aw_count", aw_cnt - aw0, 4);
    check("lim_awvalid_stalled", l2_awvalid, 1'b0);
    give_b(2'b00);
    check("lim_no_pop_same_cycle", l2_awvalid, 1'b0);
    wait_cyc(1);
    check("lim_fifth_awvalid", l2_awvalid, 1'b1);
    check("lim_fifth_awaddr", l2_awaddr, 64'h1000 + 64'((3 * 8 + 4) * 8));
    run_auto(40);
    check("lim_aw_total", aw_cnt - aw0, 6);
    check("lim_num_written", num_written, 32'd16);
    $display("outstanding limit: checks=%0d errors=%0d", checks, errors);

    // AW/W skew: wready follows awready by 3 cycles
    aw0 = aw_cnt;
    w0  = w_cnt;
    l2_awready = 1'b0;
    l2_wready  = 1'b0;
    push(4'd4, 4'd0, 32'hC000_0000, 32'h7000_0000);
    push(4'd4, 4'd1, 32'hC000_0001, 32'h7000_0001);
    wait_cyc(2);
    l2_awready = 1'b1;
    wait_cyc(3);
    check("skew_single_aw", aw_cnt - aw0, 1);
    check("skew_awvalid_low", l2_awvalid, 1'b0);
    check("skew_wvalid_held", l2_wvalid, 1'b1);
    l2_wready = 1'b1;
    wait_cyc(1);
    check("skew_w_done", w_cnt - w0, 1);
    check("skew_next_issued", l2_awvalid, 1'b1);
    run_auto(30);
    check("skew_aw_total", aw_cnt - aw0, 2);
    check("skew_w_total", w_cnt - w0, 2);
    check("skew_addr0", aw_addr_q[aw0], 64'h1100);
    check("skew_addr1", aw_addr_q[aw0+1], 64'h1108);
    check("skew_num_written", num_written, 32'd18);
    $display("aw/w skew: checks=%0d errors=%0d", checks, errors);

    // Overflow: id 8 accepted but dropped
    aw0 = aw_cnt;
    push(4'd0, 4'd8, 32'hD000_0000, 32'h8000_0000);
    wait_cyc(5);
    check("ovf_no_write", aw_cnt - aw0, 0);
    check("ovf_flag", overflow_err, 1'b1);
    check("ovf_idle", idle, 1'b1);
    $display("overflow: checks=%0d errors=%0d", checks, errors);

    // Error B response still counts as written
    aw0 = aw_cnt;
    push(4'd0, 4'd1, 32'hCAFE0001, 32'h0BAD0001);
    wait_cyc(4);
    check("berr_aw", aw_cnt - aw0, 1);
    check("berr_addr", aw_addr_q[aw0], 64'h1008);
    check("berr_flag_before", bresp_err, 1'b0);
    give_b(2'b10);
    check("berr_flag", bresp_err, 1'b1);
    check("berr_num_written", num_written, 32'd19);
    check("berr_idle", idle, 1'b1);
    $display("bresp error: checks=%0d errors=%0d", checks, errors);

    // Reset mid-flight with entries buffered
    l2_awready = 1'b0;
    l2_wready  = 1'b0;
    for (int k = 0; k < 4; k++)
      push(4'd5, 4'(k), 32'hE000_0000 + 32'(k), 32'h9000_0000 + 32'(k));
    rstn = 1'b0;
    wait_cyc(1);
    check("mrst_ready", undo_log_ready, 1'b0);
    check("mrst_awvalid", l2_awvalid, 1'b0);
    check("mrst_wvalid", l2_wvalid, 1'b0);
    check("mrst_idle", idle, 1'b1);
    check("mrst_overflow", overflow_err, 1'b0);
    check("mrst_bresp_err", bresp_err, 1'b0);
    check("mrst_num_written", num_written, 32'd0);
    wait_cyc(1);
    b_sent = 0;
    l2_awready = 1'b1;
    l2_wready  = 1'b1;
    rstn = 1'b1;
    wait_cyc(10);
    check("mrst_no_aw", aw_cnt, 0);
    check("mrst_no_w", w_cnt, 0);
    check("mrst_idle_after", idle, 1'b1);
    check("mrst_ready_after", undo_log_ready, 1'b1);
    $display("reset mid-flight: checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
